// File: rtl/mem_port_arbiter_if.sv
// Memory port bus shared by the arbiter (master) and the single-ported memory (slave).
//   mem_req   : access request, held until the completing cycle
//   mem_we    : 1 = write, 0 = read
//   mem_addr  : access address
//   mem_wdata : write data
//   mem_rdata : read data, valid when mem_req & mem_ready
//   mem_ready : access completes in the cycle where mem_req & mem_ready
interface mem_port_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch
// and the memory stage. Data accesses go first (older instruction), returned
// words are buffered, and PipeStall is held until every access the current
// cycle needs has completed. StallCount is a saturating stall-cycle counter.
//
// Ports:
//   clk, reset            : clock, synchronous active-low reset
//   IReqF, PCF            : fetch request and address
//   InstrF                : buffered instruction word
//   DReqM, DWeM           : memory-stage request, 1 = store
//   ALUResultM, WriteDataM: data address and store data
//   ReadDataM             : buffered load data
//   PipeStall             : freeze PC and pipeline registers
//   mem                   : memory port (registered request side)
//   StallCount            : cycles with PipeStall = 1, saturating
//
// state | meaning
// IDLE  | no access in flight; launches the next needed access or lets the pipe advance
// DACC  | memory-stage load/store in flight
// IACC  | instruction fetch in flight
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              IReqF,
   input  logic [ADDR_W-1:0] PCF,
   output logic [DATA_W-1:0] InstrF,
   input  logic              DReqM,
   input  logic              DWeM,
   input  logic [ADDR_W-1:0] ALUResultM,
   input  logic [DATA_W-1:0] WriteDataM,
   output logic [DATA_W-1:0] ReadDataM,
   output logic              PipeStall,
   mem_port_if.master        mem,
   output logic [CNT_W-1:0]  StallCount
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DACC = 2'd1,
      IACC = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              d_done_q, d_done_d;
   logic              i_done_q, i_done_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   logic need_d, need_i, pipe_stall, mem_done;

   always_comb begin
      need_d     = DReqM & ~d_done_q;
      need_i     = IReqF & ~i_done_q;
      pipe_stall = need_d | need_i;
      mem_done   = mem_req_q & mem.mem_ready;

      state_d     = state_q;
      d_done_d    = d_done_q;
      i_done_d    = i_done_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      instr_d     = instr_q;
      rdata_d     = rdata_q;
      stall_cnt_d = stall_cnt_q;

      if (pipe_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (need_d) begin
               state_d     = DACC;
               mem_req_d   = 1'b1;
               mem_we_d    = DWeM;
               mem_addr_d  = ALUResultM;
               mem_wdata_d = WriteDataM;
            end else if (need_i) begin
               state_d    = IACC;
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = PCF;
            end else begin
               // Nothing outstanding means PipeStall is low: the pipe advances
               // this edge, so the next cycle belongs to a new instruction pair.
               d_done_d = 1'b0;
               i_done_d = 1'b0;
            end
         end
         DACC: begin
            if (mem_done) begin
               d_done_d = 1'b1;
               if (!mem_we_q) begin
                  rdata_d = mem.mem_rdata;
               end
               if (need_i) begin
                  // Chain straight into the fetch without dropping mem_req.
                  state_d    = IACC;
                  mem_we_d   = 1'b0;
                  mem_addr_d = PCF;
               end else begin
                  state_d   = IDLE;
                  mem_req_d = 1'b0;
               end
            end
         end
         IACC: begin
            if (mem_done) begin
               i_done_d  = 1'b1;
               instr_d   = mem.mem_rdata;
               state_d   = IDLE;
               mem_req_d = 1'b0;
            end
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         d_done_q    <= 1'b0;
         i_done_q    <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         instr_q     <= '0;
         rdata_q     <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         d_done_q    <= d_done_d;
         i_done_q    <= i_done_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         instr_q     <= instr_d;
         rdata_q     <= rdata_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign PipeStall     = pipe_stall;
   assign InstrF        = instr_q;
   assign ReadDataM     = rdata_q;
   assign StallCount    = stall_cnt_q;
   assign mem.mem_req   = mem_req_q;
   assign mem.mem_we    = mem_we_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares one single-ported, variable-latency memory between the fetch stage (instruction reads) and the memory stage (loads/stores) of the five-stage pipeline. It serialises the two accesses with data priority and buffers the returned words. It holds a global pipeline stall until every access the current cycle needs has completed. It also keeps a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- IReqF  in  1  fetch stage needs an instruction this cycle
- PCF  in  ADDR_W  fetch address
- InstrF  out  DATA_W  buffered instruction word
- DReqM  in  1  memory stage holds a load or store
- DWeM  in  1  1 = store, 0 = load
- ALUResultM  in  ADDR_W  data address
- WriteDataM  in  DATA_W  store data
- ReadDataM  out  DATA_W  buffered load data
- PipeStall  out  1  freeze PC and F/D/E/M/W pipeline registers
- mem_req  out  1  memory access request (registered)
- mem_we  out  1  write enable (registered)
- mem_addr  out  ADDR_W  access address (registered)
- mem_wdata  out  DATA_W  write data (registered)
- mem_rdata  in  DATA_W  read data, valid when mem_req & mem_ready
- mem_ready  in  1  access completes in the cycle where mem_req & mem_ready
- StallCount  out  CNT_W  cycles with PipeStall = 1, saturating

## Operation
- Done flags d_done and i_done record that this cycle's data access or fetch has been serviced.
- PipeStall = (DReqM & ~d_done) | (IReqF & ~i_done). This is combinational from the inputs and the flags.
- When PipeStall = 0 the pipeline advances: at that edge both done flags clear.
- FSM states are IDLE, DACC and IACC.
  - IDLE: if DReqM & ~d_done, go to DACC. Else if IReqF & ~i_done, go to IACC. Else stay in IDLE.
  - DACC: on mem_ready, set d_done. Capture mem_rdata into ReadDataM only if mem_we = 0. Then go to IACC if IReqF & ~i_done, else go to IDLE.
  - IACC: on mem_ready, set i_done and capture mem_rdata into InstrF, then go to IDLE.
- On entry to DACC/IACC, the registered mem_req/we/addr/wdata load from ALUResultM/DWeM/WriteDataM or PCF (mem_we = 0 for fetch). They hold stable until the completing cycle. mem_req drops on the edge following mem_ready unless the next state is another access.
- A request is never withdrawn. Inputs are stable while PipeStall = 1 because the pipeline is frozen.
- Data priority: the memory-stage instruction is older, so its access is issued first.
- Stores leave ReadDataM unchanged.
- InstrF and ReadDataM hold their value until the next capture, so they remain valid on the advance cycle and afterwards.
- StallCount increments on every cycle with PipeStall = 1. It saturates at all-ones and does not wrap.

## Timing
- Reset (reset = 0 at an edge): state = IDLE, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, InstrF = 0, ReadDataM = 0, d_done = i_done = 0, StallCount = 0. PipeStall follows its equation; it is 0 with no requests.
- Reset mid-access drops mem_req on the next edge. The memory model must tolerate an abandoned request.
- Fetch only, zero-wait memory: cycle 0 IDLE with stall; cycle 1 IACC with mem_req and mem_ready; cycle 2 IDLE with i_done = 1 and stall = 0, so the pipeline advances. 2 stall cycles.
- Load + fetch, zero-wait memory: DACC at cycle 1, IACC at cycle 2, advance at cycle 3. 3 stall cycles.
- Each wait state (mem_req = 1, mem_ready = 0) adds exactly 1 stall cycle.
- No requests: PipeStall = 0 and the FSM stays in IDLE. mem_ready asserted while mem_req = 0 is ignored.
- Done flags clear and a new access cannot start in the same cycle. A new access always starts from IDLE in the cycle after the advance.

## Test plan
- Reset: hold reset = 0 for 2 cycles with IReqF = 1 -> mem_req = 0, StallCount = 0, InstrF = 0. Release reset -> mem_req rises 1 cycle later with mem_addr = PCF.
- Fetch only, PCF = 0x100, zero-wait memory returning 0x00500093 -> PipeStall high for 2 cycles, then InstrF = 0x00500093 and the pipeline advances; StallCount = 2.
- Load at 0x2000 plus fetch at 0x104 -> data access is issued first (mem_addr = 0x2000, mem_we = 0), then fetch at 0x104. ReadDataM and InstrF hold their words; 3 stall cycles.
- Store 0xDEADBEEF at 0x2004 with 2 wait states -> mem_wdata, mem_addr and mem_we held for 3 cycles. ReadDataM is unchanged; fetch follows; 5 stall cycles.
- Reset asserted during an IACC wait state -> next edge mem_req = 0, state IDLE, i_done = 0. The fetch is reissued after reset is released.
- Force 2^CNT_W + 5 stall cycles (CNT_W = 4 override) -> StallCount saturates at 15.
